// File: rtl/x86_regfile_v2_pkg.sv
// Package regfile_pkg: shared constants and helpers for the x86-style register file.
// Contents:
//   MODE_*          access mode encoding used by the write and read ports
//   REG_*           architectural register indices in the default 9-entry layout
//   access_mode_t   typed view of the mode encoding
//   is_byte_reg()   true when an index addresses a register with HI/LO lanes
package regfile_pkg;

    typedef enum logic [1:0] {
        ACC_WORD = 2'b00,
        ACC_LO   = 2'b01,
        ACC_HI   = 2'b10,
        ACC_RSVD = 2'b11
    } access_mode_t;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_LO   = 2'b01;
    localparam logic [1:0] MODE_HI   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int unsigned REG_AX = 32'd0;
    localparam int unsigned REG_BX = 32'd1;
    localparam int unsigned REG_CX = 32'd2;
    localparam int unsigned REG_DX = 32'd3;
    localparam int unsigned REG_SP = 32'd4;
    localparam int unsigned REG_BP = 32'd5;
    localparam int unsigned REG_SI = 32'd6;
    localparam int unsigned REG_DI = 32'd7;
    localparam int unsigned REG_IP = 32'd8;

    // Only the low registers expose separate byte lanes.
    function automatic logic is_byte_reg(input int unsigned idx, input int unsigned byte_regs);
        return (idx < byte_regs);
    endfunction

endpackage

// File: rtl/x86_regfile_v2_lane_merge.sv
// regfile_lane_merge: combinational next-value builder for a register write.
// Ports:
//   old_val  in   current register contents
//   data     in   write data
//   mode     in   WORD / LO / HI (reserved leaves the value untouched)
//   src_hi   in   lane writes take their byte from the upper lane of data
//   new_val  out  merged register value
module regfile_lane_merge
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32'd16
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              src_hi,
    output logic [DATA_W-1:0] new_val
);

    localparam int unsigned LANE_W = DATA_W / 32'd2;

    logic [LANE_W-1:0] src_lane_s;

    // Pick the source byte, then splice it into the addressed lane.
    always_comb begin
        if (src_hi) begin
            src_lane_s = data[DATA_W-1:LANE_W];
        end else begin
            src_lane_s = data[LANE_W-1:0];
        end
        case (mode)
            MODE_WORD: new_val = data;
            MODE_LO:   new_val = {old_val[DATA_W-1:LANE_W], src_lane_s};
            MODE_HI:   new_val = {src_lane_s, old_val[LANE_W-1:0]};
            default:   new_val = old_val;
        endcase
    end

endmodule

// File: rtl/x86_regfile_v2.sv
// x86_regfile_v2: parametrised x86-style register file.
// One write port with WORD/LO/HI lane modes, two registered read ports that
// return the post-edge register value (same-cycle writes are forwarded), and
// an IP auto-increment. Index NUM_REGS-1 is IP.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   snap_save, snap_restore          shadow bank control (REGFILE_SNAPSHOT_EN only)
//   wr_en/idx/mode/src_hi/data       write request
//   wr_err                           one-cycle pulse for a rejected write
//   rdN_en/idx/mode/align_hi         read request, N = 0,1
//   rdN_valid, rdN_data              read result one cycle after rdN_en
//   ip_inc, ip_step                  IP += ip_step
//   ip_out                           current IP
// Build option: define REGFILE_SNAPSHOT_EN to add the shadow register bank.
module x86_regfile_v2
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = 32'd16,
    parameter int unsigned NUM_REGS  = 32'd9,
    parameter int unsigned BYTE_REGS = 32'd4,
    parameter int unsigned STEP_W    = 32'd3
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef REGFILE_SNAPSHOT_EN
    input  logic                        snap_save,
    input  logic                        snap_restore,
`endif
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
    input  logic [1:0]                  wr_mode,
    input  logic                        wr_src_hi,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_err,
    input  logic                        rd0_en,
    input  logic [$clog2(NUM_REGS)-1:0] rd0_idx,
    input  logic [1:0]                  rd0_mode,
    input  logic                        rd0_align_hi,
    output logic                        rd0_valid,
    output logic [DATA_W-1:0]           rd0_data,
    input  logic                        rd1_en,
    input  logic [$clog2(NUM_REGS)-1:0] rd1_idx,
    input  logic [1:0]                  rd1_mode,
    input  logic                        rd1_align_hi,
    output logic                        rd1_valid,
    output logic [DATA_W-1:0]           rd1_data,
    input  logic                        ip_inc,
    input  logic [STEP_W-1:0]           ip_step,
    output logic [DATA_W-1:0]           ip_out
);

    localparam int unsigned LANE_W = DATA_W / 32'd2;
    localparam int unsigned IP_IDX = NUM_REGS - 32'd1;

    logic [DATA_W-1:0] regs_r      [NUM_REGS];
    logic [DATA_W-1:0] regs_next_s [NUM_REGS];
    logic [DATA_W-1:0] wr_old_s;
    logic [DATA_W-1:0] wr_new_s;
    logic [DATA_W-1:0] ip_sum_s;
    logic [DATA_W-1:0] rd0_pick_s;
    logic [DATA_W-1:0] rd1_pick_s;
    logic              wr_ok_s;
    logic              restore_s;

    // An access is legal when the index exists and lane modes hit a byte register.
    function automatic logic access_ok(input int unsigned idx, input logic [1:0] mode);
        logic ok;
        if (idx >= NUM_REGS) begin
            ok = 1'b0;
        end else begin
            case (mode)
                MODE_WORD: ok = 1'b1;
                MODE_LO:   ok = is_byte_reg(idx, BYTE_REGS);
                MODE_HI:   ok = is_byte_reg(idx, BYTE_REGS);
                default:   ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Shape a register value for a read port: lane reads land in the chosen
    // half with the other half zero; illegal accesses read as zero.
    function automatic logic [DATA_W-1:0] lane_shape(input logic [DATA_W-1:0] v,
                                                     input logic ok,
                                                     input logic [1:0] mode,
                                                     input logic align_hi);
        logic [LANE_W-1:0] lane;
        logic [DATA_W-1:0] res;
        if (mode == MODE_HI) begin
            lane = v[DATA_W-1:LANE_W];
        end else begin
            lane = v[LANE_W-1:0];
        end
        case (mode)
            MODE_WORD: res = v;
            MODE_LO,
            MODE_HI: begin
                if (align_hi) begin
                    res = {lane, {LANE_W{1'b0}}};
                end else begin
                    res = {{LANE_W{1'b0}}, lane};
                end
            end
            default:   res = {DATA_W{1'b0}};
        endcase
        if (!ok) begin
            res = {DATA_W{1'b0}};
        end else begin
            res = res;
        end
        return res;
    endfunction

`ifdef REGFILE_SNAPSHOT_EN
    logic [DATA_W-1:0] shadow_r [NUM_REGS];
    assign restore_s = snap_restore;
`else
    assign restore_s = 1'b0;
`endif

    assign wr_ok_s  = access_ok(32'(wr_idx), wr_mode);
    assign ip_sum_s = regs_r[IP_IDX] + {{(DATA_W-STEP_W){1'b0}}, ip_step};
    assign ip_out   = regs_r[IP_IDX];

    // Fetch the current contents of the write target for lane merging.
    always_comb begin
        wr_old_s = {DATA_W{1'b0}};
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(wr_idx) == i) begin
                wr_old_s = regs_r[i];
            end else begin
                wr_old_s = wr_old_s;
            end
        end
    end

    regfile_lane_merge #(
        .DATA_W (DATA_W)
    ) u_lane_merge (
        .old_val (wr_old_s),
        .data    (wr_data),
        .mode    (wr_mode),
        .src_hi  (wr_src_hi),
        .new_val (wr_new_s)
    );

    // Next-state of every register: restore > accepted write > IP increment.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_next_s[i] = regs_r[i];
`ifdef REGFILE_SNAPSHOT_EN
            if (snap_restore) begin
                regs_next_s[i] = shadow_r[i];
            end else
`endif
            if (wr_en && wr_ok_s && (32'(wr_idx) == i)) begin
                regs_next_s[i] = wr_new_s;
            end else if (ip_inc && (i == IP_IDX)) begin
                regs_next_s[i] = ip_sum_s;
            end else begin
                regs_next_s[i] = regs_r[i];
            end
        end
    end

    // Read port 0 selects from next-state values so same-cycle updates forward.
    always_comb begin
        rd0_pick_s = {DATA_W{1'b0}};
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd0_idx) == i) begin
                rd0_pick_s = regs_next_s[i];
            end else begin
                rd0_pick_s = rd0_pick_s;
            end
        end
        rd0_pick_s = lane_shape(rd0_pick_s, access_ok(32'(rd0_idx), rd0_mode),
                                rd0_mode, rd0_align_hi);
    end

    // Read port 1, identical to port 0 and fully independent of it.
    always_comb begin
        rd1_pick_s = {DATA_W{1'b0}};
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd1_idx) == i) begin
                rd1_pick_s = regs_next_s[i];
            end else begin
                rd1_pick_s = rd1_pick_s;
            end
        end
        rd1_pick_s = lane_shape(rd1_pick_s, access_ok(32'(rd1_idx), rd1_mode),
                                rd1_mode, rd1_align_hi);
    end

    // Register state, read outputs and the write-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            wr_err    <= 1'b0;
            rd0_valid <= 1'b0;
            rd0_data  <= {DATA_W{1'b0}};
            rd1_valid <= 1'b0;
            rd1_data  <= {DATA_W{1'b0}};
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= regs_next_s[i];
            end
            // A restore swallows the write entirely, including its error.
            wr_err    <= wr_en && !wr_ok_s && !restore_s;
            rd0_valid <= rd0_en;
            rd1_valid <= rd1_en;
            if (rd0_en) begin
                rd0_data <= rd0_pick_s;
            end else begin
                rd0_data <= rd0_data;
            end
            if (rd1_en) begin
                rd1_data <= rd1_pick_s;
            end else begin
                rd1_data <= rd1_data;
            end
        end
    end

`ifdef REGFILE_SNAPSHOT_EN
    // Shadow bank: save captures the live registers unless a restore is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= {DATA_W{1'b0}};
            end
        end else if (snap_save && !snap_restore) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= regs_r[i];
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_x86_regfile_v2.sv
// Directed self-checking bench for x86_regfile_v2 (default parameters).
module tb_x86_regfile_v2;

    logic        clk;
    logic        reset;
    logic        snap_save;
    logic        snap_restore;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [1:0]  wr_mode;
    logic        wr_src_hi;
    logic [15:0] wr_data;
    logic        wr_err;
    logic        rd0_en;
    logic [3:0]  rd0_idx;
    logic [1:0]  rd0_mode;
    logic        rd0_align_hi;
    logic        rd0_valid;
    logic [15:0] rd0_data;
    logic        rd1_en;
    logic [3:0]  rd1_idx;
    logic [1:0]  rd1_mode;
    logic        rd1_align_hi;
    logic        rd1_valid;
    logic [15:0] rd1_data;
    logic        ip_inc;
    logic [2:0]  ip_step;
    logic [15:0] ip_out;

    int n_total;
    int n_bad;

    x86_regfile_v2 dut (
        .clk          (clk),
        .reset        (reset),
`ifdef REGFILE_SNAPSHOT_EN
        .snap_save    (snap_save),
        .snap_restore (snap_restore),
`endif
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_mode      (wr_mode),
        .wr_src_hi    (wr_src_hi),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .rd0_en       (rd0_en),
        .rd0_idx      (rd0_idx),
        .rd0_mode     (rd0_mode),
        .rd0_align_hi (rd0_align_hi),
        .rd0_valid    (rd0_valid),
        .rd0_data     (rd0_data),
        .rd1_en       (rd1_en),
        .rd1_idx      (rd1_idx),
        .rd1_mode     (rd1_mode),
        .rd1_align_hi (rd1_align_hi),
        .rd1_valid    (rd1_valid),
        .rd1_data     (rd1_data),
        .ip_inc       (ip_inc),
        .ip_step      (ip_step),
        .ip_out       (ip_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        snap_save = 1'b0; snap_restore = 1'b0;
        wr_en = 1'b0; wr_idx = 4'd0; wr_mode = 2'b00; wr_src_hi = 1'b0; wr_data = 16'h0000;
        rd0_en = 1'b0; rd0_idx = 4'd0; rd0_mode = 2'b00; rd0_align_hi = 1'b0;
        rd1_en = 1'b0; rd1_idx = 4'd0; rd1_mode = 2'b00; rd1_align_hi = 1'b0;
        ip_inc = 1'b0; ip_step = 3'd0;
    endtask

    task automatic set_wr(input logic [3:0] idx, input logic [1:0] mode,
                          input logic src, input logic [15:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_mode = mode; wr_src_hi = src; wr_data = data;
    endtask

    task automatic set_rd0(input logic [3:0] idx, input logic [1:0] mode, input logic al);
        rd0_en = 1'b1; rd0_idx = idx; rd0_mode = mode; rd0_align_hi = al;
    endtask

    task automatic set_rd1(input logic [3:0] idx, input logic [1:0] mode, input logic al);
        rd1_en = 1'b1; rd1_idx = idx; rd1_mode = mode; rd1_align_hi = al;
    endtask

    task automatic do_wr(input logic [3:0] idx, input logic [1:0] mode,
                         input logic src, input logic [15:0] data);
        set_wr(idx, mode, src, data);
        tick();
        idle();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_rd0_valid", {15'd0, rd0_valid}, 16'h0000);
        check("rst_rd1_valid", {15'd0, rd1_valid}, 16'h0000);
        check("rst_wr_err", {15'd0, wr_err}, 16'h0000);
        check("rst_ip", ip_out, 16'h0000);
        reset = 1'b0;

        // 1: every index reads zero, valid one cycle after enable
        for (int i = 0; i < 9; i++) begin
            set_rd0(4'(i), 2'b00, 1'b0);
            set_rd1(4'(8 - i), 2'b00, 1'b0);
            tick();
            idle();
            check("t1_rd0_valid", {15'd0, rd0_valid}, 16'h0001);
            check("t1_rd0_data", rd0_data, 16'h0000);
            check("t1_rd1_valid", {15'd0, rd1_valid}, 16'h0001);
            check("t1_rd1_data", rd1_data, 16'h0000);
        end
        tick();
        check("t1_valid_drop", {15'd0, rd0_valid}, 16'h0000);

        // 2: word write, then LO lane from upper source byte
        do_wr(4'd0, 2'b00, 1'b0, 16'h1234);
        do_wr(4'd0, 2'b01, 1'b1, 16'hAB00);
        set_rd0(4'd0, 2'b00, 1'b0);
        set_rd1(4'd0, 2'b10, 1'b0);
        tick();
        idle();
        check("t2_ax", rd0_data, 16'h12AB);
        check("t2_ah", rd1_data, 16'h0012);
        set_rd0(4'd0, 2'b01, 1'b1);
        tick();
        idle();
        check("t2_al_hi", rd0_data, 16'hAB00);

        // 3: same-cycle write forwarding
        do_wr(4'd2, 2'b00, 1'b0, 16'h7777);
        set_wr(4'd1, 2'b00, 1'b0, 16'hBEEF);
        set_rd0(4'd1, 2'b00, 1'b0);
        set_rd1(4'd2, 2'b00, 1'b0);
        tick();
        idle();
        check("t3_fwd_bx", rd0_data, 16'hBEEF);
        check("t3_old_cx", rd1_data, 16'h7777);
        set_wr(4'd2, 2'b01, 1'b0, 16'h0011);
        set_rd0(4'd2, 2'b00, 1'b0);
        set_rd1(4'd1, 2'b10, 1'b1);
        tick();
        idle();
        check("t3_fwd_cl", rd0_data, 16'h7711);
        check("t3_bh_hi", rd1_data, 16'hBE00);

        // 4: IP wrap, write priority over increment, increment forwarding
        do_wr(4'd8, 2'b00, 1'b0, 16'hFFFE);
        check("t4_ip_load", ip_out, 16'hFFFE);
        ip_inc = 1'b1; ip_step = 3'd3;
        tick();
        idle();
        check("t4_ip_wrap", ip_out, 16'h0001);
        set_wr(4'd8, 2'b00, 1'b0, 16'h0100);
        ip_inc = 1'b1; ip_step = 3'd3;
        tick();
        idle();
        check("t4_wr_wins", ip_out, 16'h0100);
        ip_inc = 1'b1; ip_step = 3'd7;
        set_rd0(4'd8, 2'b00, 1'b0);
        set_rd1(4'd8, 2'b01, 1'b0);
        tick();
        idle();
        check("t4_ip_inc7", ip_out, 16'h0107);
        check("t4_rd_ip_fwd", rd0_data, 16'h0107);
        check("t4_ip_lane_rd", rd1_data, 16'h0000);
        check("t4_ip_lane_vld", {15'd0, rd1_valid}, 16'h0001);

        // 5: rejected writes
        do_wr(4'd4, 2'b00, 1'b0, 16'hCAFE);
        check("t5_ok_err", {15'd0, wr_err}, 16'h0000);
        do_wr(4'd4, 2'b01, 1'b0, 16'h1111);
        check("t5_sp_lo_err", {15'd0, wr_err}, 16'h0001);
        tick();
        check("t5_err_pulse", {15'd0, wr_err}, 16'h0000);
        do_wr(4'd9, 2'b00, 1'b0, 16'h2222);
        check("t5_idx9_err", {15'd0, wr_err}, 16'h0001);
        do_wr(4'd0, 2'b11, 1'b0, 16'h3333);
        check("t5_rsvd_err", {15'd0, wr_err}, 16'h0001);
        do_wr(4'd8, 2'b10, 1'b0, 16'h4444);
        check("t5_ip_hi_err", {15'd0, wr_err}, 16'h0001);
        set_rd0(4'd4, 2'b00, 1'b0);
        set_rd1(4'd9, 2'b00, 1'b0);
        tick();
        idle();
        check("t5_sp_kept", rd0_data, 16'hCAFE);
        check("t5_rd_idx9", rd1_data, 16'h0000);
        check("t5_rd_idx9_vld", {15'd0, rd1_valid}, 16'h0001);
        set_rd0(4'd0, 2'b00, 1'b0);
        set_rd1(4'd8, 2'b00, 1'b0);
        tick();
        idle();
        check("t5_ax_kept", rd0_data, 16'h12AB);
        check("t5_ip_kept", rd1_data, 16'h0107);
        set_rd1(4'd0, 2'b11, 1'b0);
        tick();
        idle();
        check("t5_rd_rsvd", rd1_data, 16'h0000);
        // read data holds while the port is idle
        do_wr(4'd0, 2'b00, 1'b0, 16'h0F0F);
        check("t5_hold_data", rd0_data, 16'h12AB);
        check("t5_hold_vld", {15'd0, rd0_valid}, 16'h0000);

`ifdef REGFILE_SNAPSHOT_EN
        // 6: snapshot save / restore
        snap_save = 1'b1;
        tick();
        idle();
        do_wr(4'd0, 2'b00, 1'b0, 16'h5555);
        snap_save = 1'b1; snap_restore = 1'b1;
        set_wr(4'd0, 2'b11, 1'b0, 16'h9999);
        ip_inc = 1'b1; ip_step = 3'd1;
        set_rd0(4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check("t6_restore_ax", rd0_data, 16'h0F0F);
        check("t6_restore_err", {15'd0, wr_err}, 16'h0000);
        check("t6_restore_ip", ip_out, 16'h0107);
        do_wr(4'd0, 2'b00, 1'b0, 16'h6666);
        snap_restore = 1'b1;
        tick();
        idle();
        set_rd0(4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check("t6_shadow_kept", rd0_data, 16'h0F0F);
`endif

        // reset during a read drops the request and clears state
        reset = 1'b1;
        set_rd0(4'd0, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        check("t7_rst_vld", {15'd0, rd0_valid}, 16'h0000);
        check("t7_rst_data", rd0_data, 16'h0000);
        check("t7_rst_ip", ip_out, 16'h0000);
        set_rd0(4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check("t7_ax_cleared", rd0_data, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
